// File: rtl/input_conditioner_if.sv
// Signal bundle between the raw X/Y stimulus side and the input_conditioner.
// There is no handshake: inputs are free-running levels and outputs are registered levels/pulses.
interface input_conditioner_if #(
  parameter int CNT_W = 16
);
  logic             clr;
  logic             x;
  logic             y;
  logic             xs;
  logic             ys;
  logic             xr;
  logic             yr;
  logic             xf;
  logic             yf;
  logic [CNT_W-1:0] xcnt;
  logic [CNT_W-1:0] ycnt;

  modport master (
    output clr, x, y,
    input  xs, ys, xr, yr, xf, yf, xcnt, ycnt
  );

  modport slave (
    input  clr, x, y,
    output xs, ys, xr, yr, xf, yf, xcnt, ycnt
  );
endinterface

// File: rtl/input_conditioner.sv
// Synchronises and debounces the asynchronous X/Y inputs, producing clean levels,
// one-cycle edge pulses and rising-edge counters for the downstream timing block.
module input_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 3,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input_conditioner_if.slave bus
);
  localparam int            CW     = $clog2(DEBOUNCE) + 1;
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE - 1);

  logic [1:0] raw;
  assign raw = {bus.y, bus.x};

  // Channel 0 is X, channel 1 is Y; the two share nothing but clk, rst_n and clr.
  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] s;
    logic [CW-1:0]          c;
    logic                   q;
    logic                   rise;
    logic                   fall;
    logic [CNT_W-1:0]       cnt;
    logic                   sx;
    logic                   accept;

    assign sx     = s[SYNC_STAGES-1];
    assign accept = (sx != q) && (c == C_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s    <= '0;
        c    <= '0;
        q    <= 1'b0;
        rise <= 1'b0;
        fall <= 1'b0;
        cnt  <= '0;
      end else begin
        s    <= {s[SYNC_STAGES-2:0], raw[ch]};
        rise <= accept & sx;
        fall <= accept & ~sx;
        if (sx == q || accept) begin
          c <= '0;
        end else begin
          c <= c + 1'b1;
        end
        if (accept) begin
          q <= sx;
        end
        // A clear wins over a coincident increment; that rising edge is dropped.
        if (bus.clr) begin
          cnt <= '0;
        end else if (accept && sx) begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign bus.xs   = g_ch[0].q;
  assign bus.xr   = g_ch[0].rise;
  assign bus.xf   = g_ch[0].fall;
  assign bus.xcnt = g_ch[0].cnt;
  assign bus.ys   = g_ch[1].q;
  assign bus.yr   = g_ch[1].rise;
  assign bus.yf   = g_ch[1].fall;
  assign bus.ycnt = g_ch[1].cnt;
endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: directed scenarios plus randomized X/Y/CLR
// traffic compared every cycle against a run-length reference model.
module tb_input_conditioner;
  localparam int SYNC = 2;
  localparam int DEB  = 3;

  logic clk;
  logic rst_n;

  input_conditioner_if #(.CNT_W(16)) bus ();
  input_conditioner_if #(.CNT_W(4))  bus4 ();

  input_conditioner #(.SYNC_STAGES(SYNC), .DEBOUNCE(DEB), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Narrow-counter twin sees identical inputs so counter wrap is reached quickly.
  input_conditioner #(.SYNC_STAGES(SYNC), .DEBOUNCE(DEB), .CNT_W(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  assign bus4.clr = bus.clr;
  assign bus4.x   = bus.x;
  assign bus4.y   = bus.y;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // A level is accepted once the synchronised input has disagreed with it for DEB straight cycles.
  logic [1:0]  m_sh[$];
  logic [1:0]  m_lvl;
  logic [1:0]  m_rise;
  logic [1:0]  m_fall;
  int          m_run[2];
  logic [15:0] m_cnt[2];

  task automatic m_reset();
    m_sh = {};
    for (int i = 0; i < SYNC; i++) m_sh.push_back(2'b00);
    m_lvl  = '0;
    m_rise = '0;
    m_fall = '0;
    for (int ch = 0; ch < 2; ch++) begin
      m_run[ch] = 0;
      m_cnt[ch] = '0;
    end
  endtask

  task automatic m_step();
    logic [1:0] sx;
    sx = m_sh.pop_front();
    m_sh.push_back({bus.y, bus.x});
    for (int ch = 0; ch < 2; ch++) begin
      m_rise[ch] = 1'b0;
      m_fall[ch] = 1'b0;
      if (sx[ch] == m_lvl[ch]) begin
        m_run[ch] = 0;
      end else begin
        m_run[ch]++;
        if (m_run[ch] == DEB) begin
          m_lvl[ch]  = sx[ch];
          m_run[ch]  = 0;
          m_rise[ch] = sx[ch];
          m_fall[ch] = ~sx[ch];
        end
      end
      if (bus.clr) m_cnt[ch] = '0;
      else if (m_rise[ch]) m_cnt[ch] = m_cnt[ch] + 16'd1;
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  // Every cycle, away from the active edge, compare all outputs with the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("xs",   bus.xs,   m_lvl[0]);
        check("ys",   bus.ys,   m_lvl[1]);
        check("xr",   bus.xr,   m_rise[0]);
        check("yr",   bus.yr,   m_rise[1]);
        check("xf",   bus.xf,   m_fall[0]);
        check("yf",   bus.yf,   m_fall[1]);
        check("xcnt", bus.xcnt, m_cnt[0]);
        check("ycnt", bus.ycnt, m_cnt[1]);
        check("xcnt_w4", bus4.xcnt, m_cnt[0] & 16'h000f);
        check("ycnt_w4", bus4.ycnt, m_cnt[1] & 16'h000f);
        check("xr_xf_excl", bus.xr & bus.xf, 1'b0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_xs"},   bus.xs,   0);
    check({tag, "_ys"},   bus.ys,   0);
    check({tag, "_xr"},   bus.xr,   0);
    check({tag, "_yr"},   bus.yr,   0);
    check({tag, "_xf"},   bus.xf,   0);
    check({tag, "_yf"},   bus.yf,   0);
    check({tag, "_xcnt"}, bus.xcnt, 0);
    check({tag, "_ycnt"}, bus.ycnt, 0);
  endtask

  // ---------------- stimulus ----------------
  int hi_cycles;
  int xr_seen;
  int xf_seen;
  int hold_x;
  int hold_y;

  initial begin
    rst_n   = 1'b1;
    bus.clr = 1'b0;
    bus.x   = 1'b1;
    bus.y   = 1'b1;

    // Reset with both inputs held high, release at 3 ns.
    #1 rst_n = 1'b0;
    #1 check_all_zero("rst");
    #1 rst_n = 1'b1;
    chk_en = 1;
    step(4);
    check("hold_xs_early", bus.xs, 0);
    step(1);
    check("hold_xs",   bus.xs,   1);
    check("hold_xr",   bus.xr,   1);
    check("hold_yr",   bus.yr,   1);
    check("hold_xcnt", bus.xcnt, 1);
    check("hold_ycnt", bus.ycnt, 1);
    step(1);
    check("hold_xr_drop", bus.xr, 0);

    // Two-cycle glitch must be rejected.
    bus.x = 1'b0;
    bus.y = 1'b0;
    step(8);
    bus.x = 1'b1;
    step(2);
    bus.x = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("glitch_xs", bus.xs, 0);
      check("glitch_xr", bus.xr, 0);
    end
    check("glitch_xcnt", bus.xcnt, 1);

    // Three-cycle pulse is accepted and held for exactly three cycles.
    bus.x = 1'b1;
    step(3);
    bus.x = 1'b0;
    hi_cycles = 0;
    xr_seen   = 0;
    xf_seen   = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      hi_cycles += int'(bus.xs);
      xr_seen   += int'(bus.xr);
      xf_seen   += int'(bus.xf);
    end
    check("pulse3_width", hi_cycles, 3);
    check("pulse3_xr",    xr_seen,   1);
    check("pulse3_xf",    xf_seen,   1);
    check("pulse3_xcnt",  bus.xcnt,  2);

    // CLR sampled on the same edge that sets XR.
    bus.x = 1'b1;
    step(4);
    bus.clr = 1'b1;
    step(1);
    bus.clr = 1'b0;
    check("clr_xr",   bus.xr,   1);
    check("clr_xs",   bus.xs,   1);
    check("clr_xcnt", bus.xcnt, 0);
    check("clr_ycnt", bus.ycnt, 0);

    // Reset in the middle of a debounce, released with X still high.
    bus.x = 1'b0;
    step(8);
    bus.x = 1'b1;
    step(3);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    step(4);
    check("midrst_xs_early", bus.xs, 0);
    step(1);
    check("midrst_xs",   bus.xs,   1);
    check("midrst_xr",   bus.xr,   1);
    check("midrst_xcnt", bus.xcnt, 1);

    // Both channels rise together.
    bus.x = 1'b0;
    bus.y = 1'b0;
    step(8);
    bus.x = 1'b1;
    bus.y = 1'b1;
    step(5);
    check("sim_xr",   bus.xr,   1);
    check("sim_yr",   bus.yr,   1);
    check("sim_xcnt", bus.xcnt, 2);
    check("sim_ycnt", bus.ycnt, 1);

    // Randomized traffic with occasional clears and one asynchronous reset.
    hold_x = 0;
    hold_y = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (hold_x == 0) begin
        bus.x  = 1'($urandom_range(0, 1));
        hold_x = $urandom_range(1, 6);
      end
      if (hold_y == 0) begin
        bus.y  = 1'($urandom_range(0, 1));
        hold_y = $urandom_range(1, 6);
      end
      hold_x--;
      hold_y--;
      bus.clr = ($urandom_range(0, 400) == 0);
      if (cyc == 1500) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      step(1);
    end
    bus.clr = 1'b0;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/input_conditioner.md
# input_conditioner

Front-end stage that feeds the `timing` block. It synchronises the two asynchronous stimulus inputs X and Y into the CLK domain and debounces them. It then emits clean levels, single-cycle edge pulses and 16-bit accepted-rising-edge counters, which the downstream `timing` block consumes in place of raw X/Y. Both channels are identical and fully independent.

## Interface
- SYNC_STAGES, 2, number of synchroniser flip-flops per channel; legal range 2..4.
- DEBOUNCE, 3, consecutive cycles a new synchronised level must persist before it is accepted; legal range 1..255.
- CNT_W, 16, width of the edge counters.
- CLK  in  1  single clock; all state updates on its rising edge.
- R  in  1  reset, asynchronous, active-low. R=0 clears all state immediately; release is synchronous to CLK.
- CLR  in  1  synchronous clear of XCNT/YCNT only.
- X  in  1  asynchronous raw input, channel X.
- Y  in  1  asynchronous raw input, channel Y.
- XS, YS  out  1  debounced, accepted level per channel.
- XR, YR  out  1  one-cycle pulse on each accepted 0→1 transition.
- XF, YF  out  1  one-cycle pulse on each accepted 1→0 transition.
- XCNT, YCNT  out  CNT_W  count of accepted rising edges.

## Operation
Per channel, using X as the example:
- **Synchroniser**
  - Shift chain s[0..SYNC_STAGES-1]; s[0] samples X.
  - The last stage, sx, is the only value used downstream.
- **Debounce state**: accepted level q (drives XS) and stability counter c, width ceil(log2(DEBOUNCE))+1.
- **Each edge**:
  - If sx == q: c <= 0.
  - Else if c == DEBOUNCE-1: q <= sx, c <= 0, and the matching edge pulse is set.
  - Else: c <= c+1.
- **Glitch rejection**
  - A synchronised excursion shorter than DEBOUNCE cycles is never accepted.
  - c restarts from 0 on any return to q.
- **Edge pulses**
  - XR/XF are registered and asserted on the same edge at which q changes.
  - They deassert on the following edge.
  - XR and XF are never high simultaneously.
- **Counter**
  - XCNT increments by 1 on the edge where XR is set.
  - It wraps from 2^CNT_W-1 to 0 with no flag.
  - Falling edges do not count.
- **CLR**
  - At the next edge, XCNT and YCNT are set to 0.
  - CLR has priority over a simultaneous increment; that edge is lost.
  - CLR does not affect q, c, the synchronisers or the pulses.
- **Reset** (R=0, any time, including mid-debounce): all synchronisers, q, c, pulses and counters go to 0 asynchronously.
  - XS=YS=XR=XF=YR=YF=0, XCNT=YCNT=0.
  - If X is held at 1 through reset release, XS rises, XR pulses and XCNT becomes 1 after the normal latency.
- **Channel independence**: channels X and Y never interact. Simultaneous events on both channels are all honoured in the same cycle.

## Timing
- **Latency**
  - Define edge n as the first CLK edge at which s[0] captures a new X level.
  - XS changes at edge n+SYNC_STAGES+DEBOUNCE-1, provided the level is held.
  - With defaults this is edge n+4, i.e. 5 edges including n.
- **Pulse width**: XR/XF are high for exactly one CLK period, aligned with the XS change. XCNT updates on the same edge.
- **Minimum accepted width**: the raw input must be stable for at least DEBOUNCE clock periods, plus setup/hold, to be accepted.
- **Maximum accepted rate**: at most one accepted transition per DEBOUNCE cycles per channel.
- **Output registering**: all outputs come directly from flip-flops, with no combinational path from any input to any output.

## Test plan
Period 10 ns, defaults.
- **Reset and hold-high**: X=Y=1 while R=0 → all outputs 0. After R=1 at 3 ns, XS=YS=1 with a one-cycle XR/YR 5 edges later, and XCNT=YCNT=1.
- **Glitch rejection**: X pulses high for 2 cycles, then low → XS stays 0, XR never asserts, XCNT unchanged. A 3-cycle pulse → XS high for 3 cycles, XR then XF, XCNT+1.
- **Counter wrap**: preload via 65535 accepted X rising edges (or force XCNT=16'hFFFF), then one more edge → XCNT=0 and XR asserts normally.
- **CLR collision**: CLR asserted in the same cycle XR is set → XCNT=0 next cycle, not 1. YCNT also 0. XS unaffected.
- **Reset mid-debounce**: X rises, R pulled low after 3 edges, R released with X still 1 → the full 5-edge latency restarts from release, and XCNT=1.
- **Simultaneous channels**: X and Y toggle at the same instant → XR and YR assert in the same cycle. Both counters increment, with no cross-talk.
